// File: rtl/gouram_trace_pkg.sv
// Shared types for the trace recall arbiter.
// RECALL_ARB_STATS_EN enables the per-requester stat outputs.
package gouram_trace_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam logic RECALL_ERR_DATA = 1'b0;

`ifdef RECALL_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  function automatic logic in_range(
    input logic [31:0] q,
    input int unsigned depth
  );
    return (q[31] == 1'b0) && (q < 32'(depth));
  endfunction

endpackage

// File: rtl/recall_arbiter_rr_pick.sv
// Combinational round-robin picker: first set
// request at or above ptr, wrapping around.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  int j;

  always_comb begin
    any = |req;
    idx = '0;
    j   = 0;
    // descend so the nearest hit to ptr lands last
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/recall_arbiter.sv
// Round-robin sharing of the tracker recall port.
// RECALL_ARB_STATS_EN adds stat_grants/stat_max_wait.
module recall_arbiter
  import gouram_trace_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int SIG_WIDTH      = 32,
  parameter int DEPTH          = 256,
  parameter int RECALL_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][31:0]       req_cycles_back,
  output logic [N_REQ-1:0]             req_ack,
  output logic                         rsp_valid,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [SIG_WIDTH-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic [31:0]                  trk_cycles_back,
  output logic                         trk_recalculate,
  input  logic [SIG_WIDTH-1:0]         trk_recall
`ifdef RECALL_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][15:0]       stat_grants,
  output logic [N_REQ-1:0][15:0]       stat_max_wait
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(RECALL_LATENCY + 1) + 1;

  arb_state_e    state, state_nx;
  logic [IW-1:0] rr_ptr, grant_id, win;
  logic [CW-1:0] cnt;
  logic          any, err_pend;
  logic          cap, cap_ok, cap_err, done;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (any),
    .idx (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cap_ok) state_nx = WAIT;
      WAIT: if (done)   state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  // the acked requester still holds valid for one cycle
  always_comb begin
    cap     = (state == IDLE) && any && !(|req_ack);
    cap_ok  = cap && in_range(req_cycles_back[win], DEPTH);
    cap_err = cap && !cap_ok;
    done    = (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ack         <= '0;
      rsp_valid       <= 1'b0;
      rsp_id          <= '0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      trk_cycles_back <= '0;
      trk_recalculate <= 1'b0;
      rr_ptr          <= '0;
      grant_id        <= '0;
      cnt             <= '0;
      err_pend        <= 1'b0;
    end else begin
      req_ack         <= '0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      trk_recalculate <= 1'b0;
      err_pend        <= cap_err;
      if (cap) begin
        grant_id     <= win;
        req_ack[win] <= 1'b1;
        rr_ptr       <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (cap_ok) begin
        trk_cycles_back <= req_cycles_back[win];
        trk_recalculate <= 1'b1;
        cnt             <= CW'(RECALL_LATENCY);
      end
      if ((state == WAIT) && !done) cnt <= cnt - 1'b1;
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= grant_id;
        rsp_data  <= trk_recall;
      end
      if (err_pend) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_id    <= grant_id;
        rsp_data  <= {SIG_WIDTH{RECALL_ERR_DATA}};
      end
    end
  end

`ifdef RECALL_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] wcnt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wcnt[i]          <= '0;
        stat_grants[i]   <= '0;
        stat_max_wait[i] <= '0;
      end else begin
        if (req_ack[i] && stat_grants[i] != 16'hFFFF)
          stat_grants[i] <= stat_grants[i] + 16'd1;
        if (cap && win == IW'(i)) begin
          if (wcnt[i] > stat_max_wait[i]) stat_max_wait[i] <= wcnt[i];
          wcnt[i] <= '0;
        end else if (req_valid[i] && !req_ack[i]
                     && wcnt[i] != 16'hFFFF) begin
          wcnt[i] <= wcnt[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_recall_arbiter.sv
// Directed bench for recall_arbiter (LAT=1 and LAT=3 instances).
// Stat checks run when RECALL_ARB_STATS_EN is defined.
module tb_recall_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]       a_valid, a_ack, b_valid, b_ack;
  logic [2:0][31:0] a_cb, b_cb;
  logic             a_rv, a_err, a_rc, b_rv, b_err, b_rc;
  logic [1:0]       a_id, b_id;
  logic [31:0]      a_data, a_tcb, a_rec, b_data, b_tcb, b_rec;
`ifdef RECALL_ARB_STATS_EN
  logic [2:0][15:0] a_sg, a_sw, b_sg, b_sw;
`endif

  // tracker stand-ins: recalled value encodes the query
  assign a_rec = 32'hA000_0000 | a_tcb;
  assign b_rec = 32'hB000_0000 | b_tcb;

  recall_arbiter u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_cycles_back(a_cb),
    .req_ack(a_ack), .rsp_valid(a_rv), .rsp_id(a_id),
    .rsp_data(a_data), .rsp_err(a_err),
    .trk_cycles_back(a_tcb), .trk_recalculate(a_rc),
    .trk_recall(a_rec)
`ifdef RECALL_ARB_STATS_EN
    , .stat_grants(a_sg), .stat_max_wait(a_sw)
`endif
  );

  recall_arbiter #(.RECALL_LATENCY(3)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_cycles_back(b_cb),
    .req_ack(b_ack), .rsp_valid(b_rv), .rsp_id(b_id),
    .rsp_data(b_data), .rsp_err(b_err),
    .trk_cycles_back(b_tcb), .trk_recalculate(b_rc),
    .trk_recall(b_rec)
`ifdef RECALL_ARB_STATS_EN
    , .stat_grants(b_sg), .stat_max_wait(b_sw)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack_a();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (a_ack == 3'b000 && n < 8);
    chk("ack_seen", 64'(a_ack != 3'b000), 64'(1));
  endtask

  initial begin
    logic [2:0]  exp_ack;
    logic [31:0] exp_d;
    a_valid = '0; a_cb = '0;
    b_valid = '0; b_cb = '0;

    // reset state
    tick(); tick();
    chk("rst_rv",  64'(a_rv),  64'(0));
    chk("rst_ack", 64'(a_ack), 64'(0));
    chk("rst_rc",  64'(a_rc),  64'(0));
    chk("rst_tcb", 64'(a_tcb), 64'(0));
    rst = 1'b0;
    tick();

    // single query 5, latency 1
    a_cb[0] = 32'd5; a_valid = 3'b001;
    tick();
    chk("t1_ack", 64'(a_ack), 64'(3'b001));
    chk("t1_rc",  64'(a_rc),  64'(1));
    chk("t1_tcb", 64'(a_tcb), 64'(5));
    chk("t1_rv0", 64'(a_rv),  64'(0));
    a_valid = '0;
    tick();
    chk("t1_rc0", 64'(a_rc),  64'(0));
    chk("t1_rv1", 64'(a_rv),  64'(0));
    tick();
    chk("t1_rv",  64'(a_rv),   64'(1));
    chk("t1_id",  64'(a_id),   64'(0));
    chk("t1_dat", 64'(a_data), 64'(32'hA000_0005));
    chk("t1_err", 64'(a_err),  64'(0));
    tick();
    chk("t1_pulse", 64'(a_rv), 64'(0));

    // reset while waiting; pointer is at 1 here
    a_cb[1] = 32'd7; a_valid = 3'b010;
    tick();
    chk("t5_ack", 64'(a_ack), 64'(3'b010));
    a_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rc",  64'(a_rc),  64'(0));
    chk("t5_ack0", 64'(a_ack), 64'(0));
    chk("t5_tcb", 64'(a_tcb), 64'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_norsp", 64'(a_rv), 64'(0));
    end

    // all three held: 0,1,2,0,1,2
    a_cb[0] = 32'd10; a_cb[1] = 32'd20; a_cb[2] = 32'd30;
    a_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_ack = 3'b001 << (k % 3);
      exp_d   = 32'hA000_0000 | 32'(10 * ((k % 3) + 1));
      wait_ack_a();
      chk("t2_ack", 64'(a_ack), 64'(exp_ack));
      tick();
      chk("t2_rv0", 64'(a_rv), 64'(0));
      tick();
      chk("t2_rv",  64'(a_rv),   64'(1));
      chk("t2_id",  64'(a_id),   64'(k % 3));
      chk("t2_dat", 64'(a_data), 64'(exp_d));
    end
    a_valid = '0;
    tick();

    // out of range: 256 then -1, tracker untouched
    a_cb[1] = 32'd256; a_valid = 3'b010;
    tick();
    chk("t3_ack", 64'(a_ack), 64'(3'b010));
    chk("t3_rc",  64'(a_rc),  64'(0));
    chk("t3_rv0", 64'(a_rv),  64'(0));
    a_valid = '0;
    tick();
    chk("t3_rv",  64'(a_rv),   64'(1));
    chk("t3_err", 64'(a_err),  64'(1));
    chk("t3_dat", 64'(a_data), 64'(0));
    chk("t3_id",  64'(a_id),   64'(1));
    chk("t3_rc1", 64'(a_rc),   64'(0));
    chk("t3_tcb", 64'(a_tcb),  64'(30));
    tick();
    chk("t3_rvc", 64'(a_rv),  64'(0));
    chk("t3_erc", 64'(a_err), 64'(0));
    a_cb[1] = 32'hFFFF_FFFF; a_valid = 3'b010;
    tick();
    chk("t3n_ack", 64'(a_ack), 64'(3'b010));
    a_valid = '0;
    tick();
    chk("t3n_err", 64'(a_err),  64'(1));
    chk("t3n_dat", 64'(a_data), 64'(0));
    chk("t3n_rc",  64'(a_rc),   64'(0));
    tick();
    // DEPTH-1 is still valid
    a_cb[1] = 32'd255; a_valid = 3'b010;
    tick();
    chk("t3b_rc", 64'(a_rc), 64'(1));
    a_valid = '0;
    tick(); tick();
    chk("t3b_rv",  64'(a_rv),   64'(1));
    chk("t3b_err", 64'(a_err),  64'(0));
    chk("t3b_dat", 64'(a_data), 64'(32'hA000_00FF));

    // latency 3 instance, back-to-back
    b_cb[0] = 32'd10; b_valid = 3'b001;
    tick();
    chk("t4_ack", 64'(b_ack), 64'(3'b001));
    b_valid = '0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t4_wait", 64'(b_rv), 64'(0));
    end
    tick();
    chk("t4_rv",  64'(b_rv),   64'(1));
    chk("t4_dat", 64'(b_data), 64'(32'hB000_000A));
    b_cb[1] = 32'd11; b_valid = 3'b010;
    tick();
    chk("t4b_ack", 64'(b_ack), 64'(3'b010));
    b_valid = '0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t4b_wait", 64'(b_rv), 64'(0));
    end
    tick();
    chk("t4b_rv",  64'(b_rv),   64'(1));
    chk("t4b_id",  64'(b_id),   64'(1));
    chk("t4b_dat", 64'(b_data), 64'(32'hB000_000B));

`ifdef RECALL_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst", 64'(a_sw[2]), 64'(0));
    a_cb[0] = 32'd1; a_cb[2] = 32'd2; a_valid = 3'b101;
    tick();
    chk("t6_ack0", 64'(a_ack), 64'(3'b001));
    a_valid = 3'b100;
    tick(); tick(); tick();
    chk("t6_ack2", 64'(a_ack), 64'(3'b100));
    a_valid = '0;
    tick();
    chk("t6_g2", 64'(a_sg[2]), 64'(1));
    chk("t6_w2", 64'(a_sw[2]), 64'(3));
    chk("t6_g0", 64'(a_sg[0]), 64'(1));
    chk("t6_w0", 64'(a_sw[0]), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
